// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-line instruction cache between the fetch port and the memory arbiter.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined; otherwise both outputs are tied to zero.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic        state_dbg
);

  // Memory handshake: a read request is held (iREN=1, iaddr stable) until a
  // cycle with iwait=0, in which iload carries the word and the fill ends.
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t             state;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags [SETS];
  logic [31:0]        data [SETS];
  logic [29:0]        fill_word;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               miss_start;
  logic               fill_done;
  logic [1:0]         unused_byte_off;

  assign idx             = imemaddr[IDX_W+1:2];
  assign tag             = imemaddr[31:IDX_W+2];
  assign fill_idx        = fill_word[IDX_W-1:0];
  assign fill_tag        = fill_word[29:IDX_W];
  assign unused_byte_off = imemaddr[1:0];

  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign ihit       = imemREN && (state == IDLE) && lookup_hit;
  assign miss_start = imemREN && (state == IDLE) && !lookup_hit;
  assign fill_done  = (state == FILL) && !iwait;

  assign imemload  = ihit ? data[idx] : 32'h0;
  assign iREN      = (state == FILL);
  assign iaddr     = (state == FILL) ? {fill_word, 2'b00} : 32'h0;
  assign state_dbg = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      fill_word <= '0;
    end else begin
      case (state)
        IDLE: if (miss_start) begin
          state     <= FILL;
          fill_word <= imemaddr[31:2];
        end
        FILL: if (!iwait) begin
          state           <= IDLE;
          valid[fill_idx] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (ihit)       hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fetch driver, memory responder with programmable wait states,
// and a negedge monitor that pops expected hit data and fill addresses from queues.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        state_dbg;

  icache dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count),
    .miss_count(miss_count), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;
  int wait_cycles = 0;
  int wait_cnt = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fill_q[$];
  logic [31:0] held_iaddr = 32'h0;
  logic        prev_iren = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001000A;
      32'h0000_0004: return 32'h3C050004;
      32'h0000_0008: return 32'h24030008;
      32'h0000_0010: return 32'hAC040010;
      32'h0000_0020: return 32'h00A53020;
      32'h0000_0040: return 32'h8C220040;
      default:       return 32'h0;
    endcase
  endfunction

  // Memory responder: holds iwait high for wait_cycles, then returns the word.
  initial forever begin
    @(posedge CLK);
    #2;
    if (iREN) begin
      if (wait_cnt < wait_cycles) begin
        iwait = 1'b1;
        iload = 32'hBADBAD00;
        wait_cnt++;
      end else begin
        iwait = 1'b0;
        iload = mem_val(iaddr);
      end
    end else begin
      iwait = 1'b1;
      iload = 32'h0;
      wait_cnt = 0;
    end
  end

  // Monitor: every hit pops expected data, every completed fill pops expected address.
  always @(negedge CLK) begin
    if (ihit) begin
      if (exp_q.size() == 0) check("unexpected_hit", {31'h0, ihit}, 32'h0);
      else check("imemload", imemload, exp_q.pop_front());
    end
    if (iREN) begin
      check("ihit_during_fill", {31'h0, ihit}, 32'h0);
      if (prev_iren) check("iaddr_stable", iaddr, held_iaddr);
      held_iaddr = iaddr;
      if (!iwait) begin
        if (exp_fill_q.size() == 0) check("unexpected_fill", iaddr, 32'hFFFF_FFFF);
        else check("fill_iaddr", iaddr, exp_fill_q.pop_front());
      end
    end
    prev_iren = iREN;
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit miss, input int waits);
    int cyc;
    int exp_lat;
    cyc = 0;
    wait_cycles = waits;
    imemREN = 1'b1;
    imemaddr = addr;
    exp_q.push_back(data);
    exp_hits++;
    if (miss) begin
      exp_fill_q.push_back({addr[31:2], 2'b00});
      exp_misses++;
    end
    exp_lat = miss ? 3 + waits : 1;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!ihit && cyc < 60);
    check($sformatf("latency_%08h", addr), cyc, exp_lat);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
  endtask

  task automatic check_counters(input string tag_s, input int h, input int m);
`ifdef ICACHE_STATS_EN
    check({tag_s, "_hit_count"}, hit_count, h);
    check({tag_s, "_miss_count"}, miss_count, m);
`else
    check({tag_s, "_hit_count"}, hit_count, 32'h0);
    check({tag_s, "_miss_count"}, miss_count, 32'h0);
    $display("expected hits=%0d misses=%0d (stats disabled)", h, m);
`endif
  endtask

  initial begin
    int cyc;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iREN", {31'h0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_state", {31'h0, state_dbg}, 32'h0);
    check_counters("rst", 0, 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Cold miss, hit, conflict eviction in set 0.
    fetch(32'h00, 32'h2001000A, 1, 0);
    fetch(32'h00, 32'h2001000A, 0, 0);
    fetch(32'h40, 32'h8C220040, 1, 0);
    fetch(32'h40, 32'h8C220040, 0, 0);
    fetch(32'h00, 32'h2001000A, 1, 0);

    // Slow memory: five wait states.
    fetch(32'h08, 32'h24030008, 1, 5);
    fetch(32'h08, 32'h24030008, 0, 0);

    // Branch flush mid-fill: address moves to 0x20 and the request drops.
    wait_cycles = 3;
    imemREN = 1'b1;
    imemaddr = 32'h10;
    exp_fill_q.push_back(32'h10);
    exp_misses++;
    @(posedge CLK);
    #1;
    check("midfill_started", {31'h0, iREN}, 32'h1);
    imemaddr = 32'h20;
    imemREN = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (iREN && cyc < 40);
    check("midfill_done", {31'h0, iREN}, 32'h0);
    @(posedge CLK);
    #1;
    fetch(32'h20, 32'h00A53020, 1, 0);
    fetch(32'h10, 32'hAC040010, 0, 0);
    fetch(32'h00, 32'h2001000A, 0, 0);
    check_counters("run", exp_hits, exp_misses);

    // Asynchronous reset in the middle of a long fill.
    wait_cycles = 10;
    imemREN = 1'b1;
    imemaddr = 32'h04;
    @(posedge CLK);
    #1;
    check("rstfill_started", {31'h0, iREN}, 32'h1);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("rstfill_iREN", {31'h0, iREN}, 32'h0);
    check("rstfill_iaddr", iaddr, 32'h0);
    check("rstfill_state", {31'h0, state_dbg}, 32'h0);
    imemREN = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_counters("after_rst", 0, 0);
    exp_hits = 0;
    exp_misses = 0;

    fetch(32'h00, 32'h2001000A, 1, 0);
    fetch(32'h04, 32'h3C050004, 1, 2);
    check_counters("final", exp_hits, exp_misses);

    repeat (3) @(posedge CLK);
    #1;
    check("hit_q_empty", exp_q.size(), 32'h0);
    check("fill_q_empty", exp_fill_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
